// File: rtl/systolic_psum_drain.sv
// Output end of the systolic MAC array: removes the per-column skew of the bottom-row partial sums
// and buffers aligned rows in a first-word-fall-through FIFO with a sticky overflow flag.
module systolic_psum_drain #(
  parameter int WIDTH = 16,
  parameter int COLS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         arst_in,
  input  logic [COLS*WIDTH-1:0]        psum_in,
  input  logic                         psum_valid_in,
  output logic [COLS*WIDTH-1:0]        row_out,
  output logic                         row_valid_out,
  input  logic                         row_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count_out,
  output logic                         overflow_out,
  input  logic                         clear_in
);
  localparam int RW    = COLS * WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [RW-1:0] aligned_row;
  logic          aligned_vld;

  // Deskew stage: valid delayed COLS-1 cycles, column c delayed COLS-1-c cycles
  if (COLS > 1) begin : g_vld
    logic [COLS-2:0] vld_q;
    logic [COLS-2:0] vld_d;

    always_comb begin
      vld_d    = vld_q;
      vld_d[0] = psum_valid_in;
      for (int i = 1; i < COLS - 1; i++) vld_d[i] = vld_q[i-1];
    end

    always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) vld_q <= '0;
      else         vld_q <= vld_d;
    end

    assign aligned_vld = vld_q[COLS-2];
  end else begin : g_no_vld
    assign aligned_vld = psum_valid_in;
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign aligned_row[c*WIDTH +: WIDTH] = psum_in[c*WIDTH +: WIDTH];
    end else begin : g_dly
      logic [WIDTH-1:0] dly_q [D];
      logic [WIDTH-1:0] dly_d [D];

      always_comb begin
        dly_d[0] = psum_in[c*WIDTH +: WIDTH];
        for (int i = 1; i < D; i++) dly_d[i] = dly_q[i-1];
      end

      // Data path carries no reset; a discarded row is killed by the cleared valid pipeline
      always_ff @(posedge clk) begin
        for (int i = 0; i < D; i++) dly_q[i] <= dly_d[i];
      end

      assign aligned_row[c*WIDTH +: WIDTH] = dly_q[D-1];
    end
  end

  // FIFO stage
  logic [RW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, pop, wr_en, drop;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    pop      = row_valid_out && row_ready_in;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the row
    wr_en    = aligned_vld && (!full || pop);
    drop     = aligned_vld && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clear_in) ovf_d = 1'b0;
    if (drop)     ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= aligned_row;
  end

  assign row_valid_out  = (count_q != '0);
  assign row_out        = row_valid_out ? mem_q[rd_ptr_q] : '0;
  assign fifo_count_out = count_q;
  assign overflow_out   = ovf_q;

endmodule

// File: tb/tb_systolic_psum_drain.sv
// Randomized and directed bench for systolic_psum_drain with a queue-based row FIFO reference model.
module tb_systolic_psum_drain;
  localparam int WIDTH = 16;
  localparam int COLS  = 4;
  localparam int DEPTH = 4;
  localparam int RW    = WIDTH * COLS;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          arst_in = 1'b1;
  logic [RW-1:0] psum_in = '0;
  logic          psum_valid_in = 1'b0;
  logic [RW-1:0] row_out;
  logic          row_valid_out;
  logic          row_ready_in = 1'b0;
  logic [CW-1:0] fifo_count_out;
  logic          overflow_out;
  logic          clear_in = 1'b0;

  systolic_psum_drain #(.WIDTH(WIDTH), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk(clk), .arst_in(arst_in), .psum_in(psum_in), .psum_valid_in(psum_valid_in),
    .row_out(row_out), .row_valid_out(row_valid_out), .row_ready_in(row_ready_in),
    .fifo_count_out(fifo_count_out), .overflow_out(overflow_out), .clear_in(clear_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct { int start; logic [RW-1:0] data; } flight_t;
  flight_t       fl[$];   // rows whose columns are still being presented
  logic [RW-1:0] mq[$];   // rows stored in the FIFO, head first
  logic          m_ovf = 1'b0;

  function automatic logic [RW-1:0] rnd_row();
    return {$urandom, $urandom};
  endfunction

  // One clock cycle: present inputs, advance the reference model at the edge, return at negedge.
  task automatic tick(input logic v, input logic [RW-1:0] row, input logic rdy, input logic clr);
    logic [RW-1:0] p;
    logic push, pop, drop;
    logic [RW-1:0] pdata;
    p = rnd_row();
    if (v) fl.push_back('{cyc, row});
    foreach (fl[i]) begin
      int k;
      k = cyc - fl[i].start;
      if (k >= 0 && k < COLS) p[k*WIDTH +: WIDTH] = fl[i].data[k*WIDTH +: WIDTH];
    end
    psum_in = p; psum_valid_in = v; row_ready_in = rdy; clear_in = clr;
    @(posedge clk);
    pop  = (mq.size() > 0) && rdy;
    push = 1'b0;
    pdata = '0;
    if (fl.size() > 0 && fl[0].start + COLS - 1 == cyc) begin
      push = 1'b1; pdata = fl[0].data; fl.delete(0);
    end
    drop = push && (mq.size() == DEPTH) && !pop;
    if (pop) mq.delete(0);
    if (push && !drop) mq.push_back(pdata);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (row_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", row_valid_out); end
    checks++; if (fifo_count_out !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow_out); end
    checks++; if (row_out !== '0) begin errors++; $display("FAIL reset_row got=%h exp=0", row_out); end
    @(negedge clk);
    arst_in = 1'b0;
  endtask

  task automatic test_single_row();
    logic [RW-1:0] r;
    r = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    tick(1'b1, r, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (row_valid_out !== (k == 4)) begin errors++; $display("FAIL single_valid t+%0d got=%b exp=%b", k, row_valid_out, (k == 4)); end
      if (k < 4) tick(1'b0, '0, 1'b0, 1'b0);
    end
    checks++; if (row_out !== r) begin errors++; $display("FAIL single_row got=%h exp=%h", row_out, r); end
    checks++; if (fifo_count_out !== CW'(1)) begin errors++; $display("FAIL single_count got=%0d exp=1", fifo_count_out); end
    tick(1'b0, '0, 1'b1, 1'b0);
    checks++; if (row_valid_out !== 1'b0 || fifo_count_out !== '0) begin errors++; $display("FAIL single_drain got=%b/%0d exp=0/0", row_valid_out, fifo_count_out); end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] rows [3];
    for (int i = 0; i < 3; i++) rows[i] = rnd_row();
    for (int i = 0; i < 3; i++) tick(1'b1, rows[i], 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    for (int k = 4; k <= 7; k++) begin
      if (k < 7) begin
        checks++; if (row_valid_out !== 1'b1 || row_out !== rows[k-4]) begin errors++; $display("FAIL b2b_row%0d got=%b/%h exp=1/%h", k-4, row_valid_out, row_out, rows[k-4]); end
      end else begin
        checks++; if (row_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", row_valid_out); end
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%b exp=0", overflow_out); end
  endtask

  task automatic test_overflow();
    logic [RW-1:0] rows [5];
    for (int i = 0; i < 5; i++) rows[i] = rnd_row();
    for (int k = 0; k < 8; k++) tick(k < 5, (k < 5) ? rows[k % 5] : '0, 1'b0, 1'b0);
    // now in cycle t+8: fifth push dropped at the t+7 edge
    checks++; if (fifo_count_out !== CW'(4)) begin errors++; $display("FAIL ovf_count got=%0d exp=4", fifo_count_out); end
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow_out); end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        checks++; if (row_valid_out !== 1'b1 || row_out !== rows[i]) begin errors++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, row_valid_out, row_out, rows[i]); end
      end else begin
        checks++; if (row_valid_out !== 1'b0) begin errors++; $display("FAIL ovf_lost got=%b exp=0", row_valid_out); end
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_clear_and_full_push_pop();
    logic [RW-1:0] rows [5];
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL clear_alone got=%b exp=0", overflow_out); end
    for (int i = 0; i < 5; i++) rows[i] = rnd_row();
    for (int k = 0; k < 7; k++) tick(k < 4, (k < 4) ? rows[k % 4] : '0, 1'b0, 1'b0);
    checks++; if (fifo_count_out !== CW'(4)) begin errors++; $display("FAIL fpp_fill got=%0d exp=4", fifo_count_out); end
    tick(1'b1, rows[4], 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    checks++; if (fifo_count_out !== CW'(4)) begin errors++; $display("FAIL fpp_count got=%0d exp=4", fifo_count_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b exp=0", overflow_out); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (row_valid_out !== 1'b1 || row_out !== rows[i]) begin errors++; $display("FAIL fpp_order%0d got=%b/%h exp=1/%h", i, row_valid_out, row_out, rows[i]); end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_clear_vs_drop();
    for (int k = 0; k < 8; k++) tick(k < 5, rnd_row(), 1'b0, 1'b0);
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL cvd_set got=%b exp=1", overflow_out); end
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL cvd_clear got=%b exp=0", overflow_out); end
    tick(1'b1, rnd_row(), 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL cvd_drop_wins got=%b exp=1", overflow_out); end
    checks++; if (fifo_count_out !== CW'(4)) begin errors++; $display("FAIL cvd_count got=%0d exp=4", fifo_count_out); end
    for (int k = 0; k < 5; k++) tick(1'b0, '0, 1'b1, 1'b1);
    checks++; if (overflow_out !== 1'b0 || row_valid_out !== 1'b0) begin errors++; $display("FAIL cvd_drain got=%b/%b exp=0/0", overflow_out, row_valid_out); end
  endtask

  task automatic test_reset_mid_row();
    logic [RW-1:0] r;
    tick(1'b1, rnd_row(), 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, rnd_row(), 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    #2 arst_in = 1'b1;
    #1;
    checks++; if (row_valid_out !== 1'b0 || fifo_count_out !== '0 || overflow_out !== 1'b0 || row_out !== '0)
      begin errors++; $display("FAIL midrst_outputs got=%b/%0d/%b/%h exp=0/0/0/0", row_valid_out, fifo_count_out, overflow_out, row_out); end
    fl.delete(); mq.delete(); m_ovf = 1'b0;
    @(posedge clk); cyc++;
    @(negedge clk); arst_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, '0, 1'b0, 1'b0);
      checks++; if (row_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_ghost k=%0d got=%b exp=0", k, row_valid_out); end
    end
    r = rnd_row();
    tick(1'b1, r, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) tick(1'b0, '0, 1'b1, 1'b0);
    checks++; if (row_valid_out !== 1'b1 || row_out !== r) begin errors++; $display("FAIL midrst_fresh got=%b/%h exp=1/%h", row_valid_out, row_out, r); end
    tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick($urandom_range(0, 1) == 1, rnd_row(), $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
      checks++; if (row_valid_out !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, row_valid_out, (mq.size() > 0)); end
      checks++; if (fifo_count_out !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, fifo_count_out, mq.size()); end
      checks++; if (overflow_out !== m_ovf) begin errors++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, overflow_out, m_ovf); end
      if (mq.size() > 0) begin
        checks++; if (row_out !== mq[0]) begin errors++; $display("FAIL rnd_row n=%0d got=%h exp=%h", n, row_out, mq[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_overflow();
    test_clear_and_full_push_pop();
    test_clear_vs_drop();
    test_reset_mid_row();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
